// File: rtl/ser_bit_feeder.sv
// ser_bit_feeder: buffers variable-length parallel words in a small FIFO and
// shifts them out MSB-first as a gapless serial bit stream on X.
module ser_bit_feeder #(
   parameter int   WIDTH    = 32,
   parameter int   DEPTH    = 2,
   parameter logic IDLE_BIT = 1'b0
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     LOAD_VALID,
   output logic                     LOAD_READY,
   input  logic [WIDTH-1:0]         LOAD_WORD,
   input  logic [$clog2(WIDTH):0]   LOAD_LEN,
   output logic                     X,
   output logic                     X_VALID,
   output logic                     FIRST,
   output logic                     LAST,
   output logic                     BUSY,
   output logic                     LEN_ERR
);
   localparam int LW = $clog2(WIDTH) + 1;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] word_mem_q [DEPTH];
   logic [WIDTH-1:0] word_mem_d [DEPTH];
   logic [LW-1:0]    len_mem_q [DEPTH];
   logic [LW-1:0]    len_mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [LW-1:0]    rem_q, rem_d;
   logic             x_q, x_d, xv_q, xv_d, first_q, first_d, last_q, last_d;
   logic             len_err_q, len_err_d;
   logic             len_ok, acc, push, pop;
   logic [WIDTH-1:0] head_word;
   logic [LW-1:0]    head_len;

   assign LOAD_READY = RST & (cnt_q != CW'(DEPTH));
   assign X          = x_q;
   assign X_VALID    = xv_q;
   assign FIRST      = first_q;
   assign LAST       = last_q;
   assign LEN_ERR    = len_err_q;
   assign BUSY       = (cnt_q != '0) | (state_q == SHIFT);

   always_comb begin
      word_mem_d = word_mem_q;
      len_mem_d  = len_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      state_d    = state_q;
      sh_d       = sh_q;
      rem_d      = rem_q;
      x_d        = x_q;
      xv_d       = xv_q;
      first_d    = first_q;
      last_d     = last_q;
      len_ok     = (LOAD_LEN != '0) && (LOAD_LEN <= LW'(WIDTH));
      acc        = LOAD_VALID & LOAD_READY;
      push       = acc & len_ok;
      pop        = (cnt_q != '0) && ((state_q == IDLE) || (rem_q == '0));
      head_word  = word_mem_q[rd_ptr_q];
      head_len   = len_mem_q[rd_ptr_q];
      len_err_d  = acc & ~len_ok;
      cnt_d      = cnt_q + CW'(push) - CW'(pop);
      // Words are stored left-aligned so the first bit always sits at the MSB
      if (push) begin
         word_mem_d[wr_ptr_q] = LOAD_WORD << (WIDTH - int'(LOAD_LEN));
         len_mem_d[wr_ptr_q]  = LOAD_LEN;
         wr_ptr_d             = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         state_d  = SHIFT;
         x_d      = head_word[WIDTH-1];
         sh_d     = head_word << 1;
         xv_d     = 1'b1;
         first_d  = 1'b1;
         last_d   = head_len == LW'(1);
         rem_d    = head_len - LW'(1);
      end else if (state_q == SHIFT && rem_q != '0) begin
         x_d     = sh_q[WIDTH-1];
         sh_d    = sh_q << 1;
         first_d = 1'b0;
         last_d  = rem_q == LW'(1);
         rem_d   = rem_q - LW'(1);
      end else begin
         state_d = IDLE;
         x_d     = IDLE_BIT;
         xv_d    = 1'b0;
         first_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         sh_q      <= '0;
         rem_q     <= '0;
         x_q       <= IDLE_BIT;
         xv_q      <= 1'b0;
         first_q   <= 1'b0;
         last_q    <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         rem_q     <= rem_d;
         x_q       <= x_d;
         xv_q      <= xv_d;
         first_q   <= first_d;
         last_q    <= last_d;
         len_err_q <= len_err_d;
      end
   end

   always_ff @(posedge CLK) begin
      word_mem_q <= word_mem_d;
      len_mem_q  <= len_mem_d;
   end
endmodule

// File: tb/tb_ser_bit_feeder.sv
// tb_ser_bit_feeder: directed vector table plus hand-written multi-cycle
// sequences for ser_bit_feeder (WIDTH=32, DEPTH=2, IDLE_BIT=0).
module tb_ser_bit_feeder;
   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        LOAD_VALID = 1'b0;
   logic        LOAD_READY;
   logic [31:0] LOAD_WORD = '0;
   logic [5:0]  LOAD_LEN = '0;
   logic        X, X_VALID, FIRST, LAST, BUSY, LEN_ERR;
   int          errs = 0;
   int          checks = 0;

   typedef struct {
      logic        rst, vld;
      logic [31:0] word;
      logic [5:0]  len;
      logic        x, xv, first, last, busy, ready, err;
   } vec_t;

   vec_t tbl[$];

   ser_bit_feeder #(.WIDTH(32), .DEPTH(2), .IDLE_BIT(1'b0)) dut (
      .CLK(CLK), .RST(RST), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
      .LOAD_WORD(LOAD_WORD), .LOAD_LEN(LOAD_LEN), .X(X), .X_VALID(X_VALID),
      .FIRST(FIRST), .LAST(LAST), .BUSY(BUSY), .LEN_ERR(LEN_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, vld, input logic [31:0] word, input logic [5:0] len,
                               input logic x, xv, first, last, busy, ready, err);
      vec_t v;
      v.rst = rst; v.vld = vld; v.word = word; v.len = len;
      v.x = x; v.xv = xv; v.first = first; v.last = last;
      v.busy = busy; v.ready = ready; v.err = err;
      return v;
   endfunction

   task automatic do_reset;
      RST = 1'b0;
      LOAD_VALID = 1'b0;
      tick();
      tick();
      RST = 1'b1;
   endtask

   initial begin
      logic [24:0] w25;
      logic [31:0] wa, wb;
      // reset state
      tbl.push_back(mk(0, 0, 32'h0, 6'd0,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 32'h0, 6'd0,  0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 32'h0, 6'd0,  0, 0, 0, 0, 0, 1, 0));
      // single-bit word
      tbl.push_back(mk(1, 1, 32'h1, 6'd1,  0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(1, 0, 32'h0, 6'd0,  1, 1, 1, 1, 1, 1, 0));
      tbl.push_back(mk(1, 0, 32'h0, 6'd0,  0, 0, 0, 0, 0, 1, 0));
      // back-to-back 1001 / 101, no gap
      tbl.push_back(mk(1, 1, 32'h9, 6'd4,  0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(1, 1, 32'h5, 6'd3,  1, 1, 1, 0, 1, 1, 0));
      tbl.push_back(mk(1, 0, 32'h0, 6'd0,  0, 1, 0, 0, 1, 1, 0));
      tbl.push_back(mk(1, 0, 32'h0, 6'd0,  0, 1, 0, 0, 1, 1, 0));
      tbl.push_back(mk(1, 0, 32'h0, 6'd0,  1, 1, 0, 1, 1, 1, 0));
      tbl.push_back(mk(1, 0, 32'h0, 6'd0,  1, 1, 1, 0, 1, 1, 0));
      tbl.push_back(mk(1, 0, 32'h0, 6'd0,  0, 1, 0, 0, 1, 1, 0));
      tbl.push_back(mk(1, 0, 32'h0, 6'd0,  1, 1, 0, 1, 1, 1, 0));
      tbl.push_back(mk(1, 0, 32'h0, 6'd0,  0, 0, 0, 0, 0, 1, 0));
      // illegal lengths are discarded with a one-cycle error pulse
      tbl.push_back(mk(1, 1, 32'hFFFFFFFF, 6'd0,  0, 0, 0, 0, 0, 1, 1));
      tbl.push_back(mk(1, 0, 32'h0, 6'd0,         0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 1, 32'hFFFFFFFF, 6'd33, 0, 0, 0, 0, 0, 1, 1));
      tbl.push_back(mk(1, 0, 32'h0, 6'd0,         0, 0, 0, 0, 0, 1, 0));

      foreach (tbl[i]) begin
         RST = tbl[i].rst;
         LOAD_VALID = tbl[i].vld;
         LOAD_WORD = tbl[i].word;
         LOAD_LEN = tbl[i].len;
         tick();
         chk($sformatf("vec%0d.x", i),     32'(X),          32'(tbl[i].x));
         chk($sformatf("vec%0d.xv", i),    32'(X_VALID),    32'(tbl[i].xv));
         chk($sformatf("vec%0d.first", i), 32'(FIRST),      32'(tbl[i].first));
         chk($sformatf("vec%0d.last", i),  32'(LAST),       32'(tbl[i].last));
         chk($sformatf("vec%0d.busy", i),  32'(BUSY),       32'(tbl[i].busy));
         chk($sformatf("vec%0d.ready", i), 32'(LOAD_READY), 32'(tbl[i].ready));
         chk($sformatf("vec%0d.err", i),   32'(LEN_ERR),    32'(tbl[i].err));
      end
      LOAD_VALID = 1'b0;

      // 25-bit word streamed MSB-first
      do_reset();
      w25 = 25'b1001001100100001001001001;
      LOAD_VALID = 1'b1; LOAD_WORD = 32'(w25); LOAD_LEN = 6'd25;
      tick();
      LOAD_VALID = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         chk($sformatf("t1.x%0d", i),     32'(X),       32'(w25[24-i]));
         chk($sformatf("t1.xv%0d", i),    32'(X_VALID), 32'd1);
         chk($sformatf("t1.first%0d", i), 32'(FIRST),   32'(i == 0));
         chk($sformatf("t1.last%0d", i),  32'(LAST),    32'(i == 24));
      end
      tick();
      chk("t1.idle_x", 32'(X), 32'd0);
      chk("t1.idle_xv", 32'(X_VALID), 32'd0);
      chk("t1.idle_busy", 32'(BUSY), 32'd0);

      // backpressure while a 32-bit word shifts
      do_reset();
      wa = 32'hA5A50F0F;
      wb = 32'h3C00FF01;
      LOAD_VALID = 1'b1; LOAD_WORD = wa; LOAD_LEN = 6'd32;
      tick();
      chk("t3.ready1", 32'(LOAD_READY), 32'd1);
      LOAD_WORD = wb;
      tick();
      chk("t3.ready2", 32'(LOAD_READY), 32'd1);
      chk("t3.a_bit0", 32'(X), 32'(wa[31]));
      LOAD_WORD = 32'h12345678;
      for (int j = 3; j <= 33; j++) begin
         tick();
         chk($sformatf("t3.ready_e%0d", j), 32'(LOAD_READY), 32'd0);
         chk($sformatf("t3.a_bit%0d", j - 2), 32'(X), 32'(wa[33-j]));
      end
      chk("t3.a_last", 32'(LAST), 32'd1);
      LOAD_WORD = 32'hDEADBEEF;
      tick();
      LOAD_VALID = 1'b0;
      chk("t3.ready_back", 32'(LOAD_READY), 32'd1);
      chk("t3.b_first", 32'(FIRST), 32'd1);
      chk("t3.b_bit0", 32'(X), 32'(wb[31]));

      // reset in the middle of a word with one word queued
      do_reset();
      LOAD_VALID = 1'b1; LOAD_WORD = 32'(w25); LOAD_LEN = 6'd25;
      tick();
      LOAD_WORD = 32'h7; LOAD_LEN = 6'd3;
      tick();
      LOAD_VALID = 1'b0;
      for (int i = 1; i < 9; i++) tick();
      chk("t5.pre_x", 32'(X), 32'(w25[16]));
      RST = 1'b0;
      tick();
      chk("t5.rst_x", 32'(X), 32'd0);
      chk("t5.rst_xv", 32'(X_VALID), 32'd0);
      chk("t5.rst_busy", 32'(BUSY), 32'd0);
      chk("t5.rst_ready", 32'(LOAD_READY), 32'd0);
      RST = 1'b1;
      tick();
      chk("t5.after_busy", 32'(BUSY), 32'd0);
      chk("t5.after_xv", 32'(X_VALID), 32'd0);
      chk("t5.after_ready", 32'(LOAD_READY), 32'd1);
      LOAD_VALID = 1'b1; LOAD_WORD = 32'h5; LOAD_LEN = 6'd3;
      tick();
      LOAD_VALID = 1'b0;
      tick();
      chk("t5.new_first", 32'(FIRST), 32'd1);
      chk("t5.new_x", 32'(X), 32'd1);
      chk("t5.new_xv", 32'(X_VALID), 32'd1);
      tick();
      chk("t5.new_x1", 32'(X), 32'd0);
      tick();
      chk("t5.new_last", 32'(LAST), 32'd1);
      tick();
      chk("t5.end_busy", 32'(BUSY), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
